pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register with a valid/ready handshake, a two-entry skid buffer and a synchronous flush that can insert a bubble. It is the generic replacement for the fixed IF/ID latch and can sit between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage carries a data payload and a PC. A stalled consumer no longer forces the producer to re-present data, because `in_ready` is registered.

---
 rtl/pipe_stage_reg.sv | 122 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake, a two-entry
// skid buffer and a synchronous flush that can leave a bubble entry behind.
module pipe_stage_reg #(
    parameter int unsigned           DATA_W       = 32,
    parameter int unsigned           PC_W         = 32,
    parameter logic [PC_W-1:0]       RESET_PC     = PC_W'(32'h8000_0000),
    parameter logic [DATA_W-1:0]     BUBBLE_DATA  = '0,
    parameter bit                    FLUSH_BUBBLE = 1'b1,
    parameter int unsigned           PC_STEP      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e            state_q,     state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [PC_W-1:0]   main_pc_q,   main_pc_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [PC_W-1:0]   skid_pc_q,   skid_pc_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Next-state and datapath selection; flush overrides the handshake.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_pc_d   = main_pc_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;

        if (flush) begin
            if (FLUSH_BUBBLE) begin
                state_d     = ST_FULL;
                main_data_d = BUBBLE_DATA;
                main_pc_d   = in_pc - PC_W'(PC_STEP);
            end else begin
                state_d = ST_EMPTY;
            end
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_data_d = in_data;
                        main_pc_d   = in_pc;
                        state_d     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_data_d = in_data;
                        main_pc_d   = in_pc;
                    end else if (in_xfer) begin
                        skid_data_d = in_data;
                        skid_pc_d   = in_pc;
                        state_d     = ST_SKID;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        main_data_d = skid_data_q;
                        main_pc_d   = skid_pc_q;
                        state_d     = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        in_ready_d  = (state_d != ST_SKID);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= BUBBLE_DATA;
            main_pc_q   <= RESET_PC;
            skid_data_q <= BUBBLE_DATA;
            skid_pc_q   <= RESET_PC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_pc_q   <= main_pc_d;
            skid_data_q <= skid_data_d;
            skid_pc_q   <= skid_pc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_pc    = main_pc_q;
    assign count     = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: a queue-based scoreboard of the stage contents plus a
// vector table and hand sequences for stall, skid, flush and wrap cases.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_data, in_pc;
    logic        in_ready, out_valid;
    logic [31:0] out_data, out_pc;
    logic [1:0]  count;
    logic        nb_in_ready, nb_out_valid;
    logic [31:0] nb_out_data, nb_out_pc;
    logic [1:0]  nb_count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    ent_t mq[$];
    ent_t last;

    typedef struct {
        logic        rst, fl, iv;
        logic [31:0] d, p;
        logic        ordy;
        logic [1:0]  exp_count;
        logic        exp_ir;
    } vec_t;

    vec_t tbl[15];

    pipe_stage_reg #(.FLUSH_BUBBLE(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pc(out_pc), .count(count)
    );

    pipe_stage_reg #(.FLUSH_BUBBLE(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(nb_in_ready), .in_data(in_data), .in_pc(in_pc),
        .out_valid(nb_out_valid), .out_ready(out_ready), .out_data(nb_out_data),
        .out_pc(nb_out_pc), .count(nb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // One clock: drive inputs, update the reference model at the edge, compare 1 time unit later.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [31:0] d, input logic [31:0] p, input logic ordy);
        bit can_in, out_x;
        reset = r; flush = f; in_valid = iv; in_data = d; in_pc = p; out_ready = ordy;
        @(posedge clk);
        if (r) begin
            mq.delete();
            last = '{data: 32'h0, pc: 32'h8000_0000};
        end else if (f) begin
            mq.delete();
            mq.push_back('{data: 32'h0, pc: p - 32'd4});
        end else begin
            can_in = (mq.size() < 2);
            out_x  = (mq.size() > 0) && ordy;
            if (out_x) void'(mq.pop_front());
            if (iv && can_in) mq.push_back('{data: d, pc: p});
        end
        if (mq.size() > 0) last = mq[0];
        #1;
        check("count",     64'(count),     64'(mq.size()));
        check("in_ready",  64'(in_ready),  64'(mq.size() < 2));
        check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        check("out_data",  64'(out_data),  64'(last.data));
        check("out_pc",    64'(out_pc),    64'(last.pc));
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_pc = '0;
        last = '{data: 32'h0, pc: 32'h8000_0000};

        tbl[0]  = '{0, 0, 1, 32'hA, 32'h100, 0, 2'd1, 1'b1};
        tbl[1]  = '{0, 0, 1, 32'hB, 32'h104, 0, 2'd2, 1'b0};
        tbl[2]  = '{0, 0, 1, 32'hC, 32'h108, 0, 2'd2, 1'b0};
        tbl[3]  = '{0, 0, 1, 32'hC, 32'h108, 1, 2'd1, 1'b1};
        tbl[4]  = '{0, 0, 1, 32'hC, 32'h108, 0, 2'd2, 1'b0};
        tbl[5]  = '{0, 0, 0, 32'h0, 32'h0,   1, 2'd1, 1'b1};
        tbl[6]  = '{0, 0, 0, 32'h0, 32'h0,   1, 2'd0, 1'b1};
        tbl[7]  = '{0, 0, 1, 32'hD, 32'h200, 0, 2'd1, 1'b1};
        tbl[8]  = '{0, 0, 1, 32'hE, 32'h204, 0, 2'd2, 1'b0};
        tbl[9]  = '{0, 1, 1, 32'hF, 32'h8000_0010, 1, 2'd1, 1'b1};
        tbl[10] = '{0, 0, 0, 32'h0, 32'h0,   1, 2'd0, 1'b1};
        tbl[11] = '{0, 1, 0, 32'h0, 32'h2,   0, 2'd1, 1'b1};
        tbl[12] = '{0, 1, 0, 32'h0, 32'h20,  0, 2'd1, 1'b1};
        tbl[13] = '{0, 0, 1, 32'h77, 32'h300, 0, 2'd2, 1'b0};
        tbl[14] = '{1, 1, 1, 32'h88, 32'h400, 0, 2'd0, 1'b1};

        // Reset for two cycles, then release and confirm reset values.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_count",     64'(count),     64'(0));
        check("rst_out_pc",    64'(out_pc),    64'(32'h8000_0000));
        check("rst_out_data",  64'(out_data),  64'(0));

        // Streaming: one entry per cycle, each visible right after its edge.
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 32'h1000 + 32'(i), 32'h8000_0004 + 32'(4 * i), 1);
            check("stream_data", 64'(out_data), 64'(32'h1000 + 32'(i)));
            check("stream_pc",   64'(out_pc),   64'(32'h8000_0004 + 32'(4 * i)));
            check("stream_count_le1", 64'(count <= 2'd1), 64'(1));
        end
        step(0, 0, 0, 0, 0, 1);

        // Stall/skid, flush with bubble, wrap, back-to-back flush, reset over flush.
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].p, tbl[i].ordy);
            check("tbl_count",    64'(count),    64'(tbl[i].exp_count));
            check("tbl_in_ready", 64'(in_ready), 64'(tbl[i].exp_ir));
            if (i == 9)  check("bubble_pc", 64'(out_pc), 64'(32'h8000_000C));
            if (i == 11) check("wrap_pc",   64'(out_pc), 64'(32'hFFFF_FFFE));
            if (i == 14) check("rst_over_flush_pc", 64'(out_pc), 64'(32'h8000_0000));
        end

        // Flush without bubble from FULL.
        step(0, 0, 1, 32'h55, 32'h8000_0040, 0);
        check("nb_full_count", 64'(nb_count), 64'(1));
        step(0, 1, 0, 0, 32'h8000_0050, 0);
        check("nb_count",     64'(nb_count),     64'(0));
        check("nb_out_valid", 64'(nb_out_valid), 64'(0));
        check("nb_out_pc",    64'(nb_out_pc),    64'(32'h8000_0040));
        check("nb_out_data",  64'(nb_out_data),  64'(32'h55));
        check("nb_in_ready",  64'(nb_in_ready),  64'(1));
        check("b_flush_pc",   64'(out_pc),       64'(32'h8000_004C));

        // Drain and refill to confirm ordering through the skid after flushes.
        step(0, 0, 1, 32'h61, 32'h500, 0);
        step(0, 0, 1, 32'h62, 32'h504, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
